dcache_bus_responder: RTL and testbench

- Bus-side responder for the dcache refill/write-back port. Accepts the dcache's read and write requests and answers with ready handshakes and returned data beats.
- Backed by an internal word-addressed memory with a programmable read latency.
- Serves as the on-chip memory model for dcache bring-up and verification, and as a scratchpad behind the cache.

---
 rtl/dcache_bus_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_bus_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_bus_responder.sv
// Bus-side memory responder for the dcache refill/write-back port: word-addressed
// memory, programmable read latency, 4-beat line bursts. Optional macro DCACHE_RESP_RANDOM_STALL_EN.
module dcache_bus_responder #(
    parameter int    MEM_WORDS = 4096,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int AW       = $clog2(MEM_WORDS);
    localparam int LAT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int LAT_LOAD = (LATENCY >= 2) ? (LATENCY - 2) : 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_mem [MEM_WORDS];
    logic [AW-1:0]     r_idx;
    logic              r_line;
    logic [1:0]        r_beat;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_ret_valid;
    logic              r_ret_last;
    logic [31:0]       r_ret_data;

    logic              w_rdy_ok;
    logic              w_beat_ok;
    logic              w_wr_rdy;
    logic              w_rd_rdy;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AW-1:0]     w_rd_idx;
    logic [AW-1:0]     w_wr_idx;
    logic              w_rd_line;
    logic [AW-1:0]     w_src_idx;
    logic              w_src_line;
    logic [1:0]        w_src_beat;
    logic [AW-1:0]     w_issue_idx;
    logic              w_issue_last;
    logic              w_issue;
    logic              w_ret_last_nxt;
    logic [31:0]       w_ret_data_nxt;
    logic              w_unused_ok;

`ifdef DCACHE_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that injects ready and beat stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_rdy_ok  = ~r_lfsr[0];
    assign w_beat_ok = ~r_lfsr[1];
`else
    assign w_rdy_ok  = 1'b1;
    assign w_beat_ok = 1'b1;
`endif

    // Write wins over read so a dirty write-back always lands before its refill.
    assign w_wr_rdy  = (r_state == IDLE) && !reset && w_rdy_ok;
    assign w_rd_rdy  = w_wr_rdy && !wr_req;
    assign w_wr_acc  = wr_req && w_wr_rdy;
    assign w_rd_acc  = rd_req && w_rd_rdy;
    assign w_rd_idx  = rd_addr[AW+1:2];
    assign w_wr_idx  = wr_addr[AW+1:2];
    assign w_rd_line = (rd_type == 3'b100);

    assign rd_rdy    = w_rd_rdy;
    assign wr_rdy    = w_wr_rdy;
    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;
    assign ret_data  = r_ret_data;

    assign w_unused_ok = &{1'b0, rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rd_acc) begin
                    w_state_nxt = (LATENCY == 1) ? RD_BURST : RD_WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = RD_BURST;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_BURST: begin
                if (r_ret_valid && r_ret_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RD_BURST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beat source: the live request when issuing straight from IDLE, otherwise the latched read.
    always_comb begin
        if (r_state == IDLE) begin
            w_src_idx  = w_rd_idx;
            w_src_line = w_rd_line;
            w_src_beat = 2'd0;
        end else begin
            w_src_idx  = r_idx;
            w_src_line = r_line;
            w_src_beat = r_beat;
        end
        if (w_src_line) begin
            w_issue_idx  = {w_src_idx[AW-1:2], w_src_beat};
            w_issue_last = (w_src_beat == 2'd3);
        end else begin
            w_issue_idx  = w_src_idx;
            w_issue_last = 1'b1;
        end
    end

    // FSM output logic: decides whether a beat issues at this edge and what it carries.
    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue = w_rd_acc && (LATENCY == 1);
            end
            RD_WAIT: begin
                w_issue = (r_lat_cnt == '0);
            end
            RD_BURST: begin
                w_issue = !(r_ret_valid && r_ret_last) && w_beat_ok;
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
        if (w_issue) begin
            w_ret_last_nxt = w_issue_last;
            w_ret_data_nxt = r_mem[w_issue_idx];
        end else begin
            w_ret_last_nxt = 1'b0;
            w_ret_data_nxt = r_ret_data;
        end
    end

    // Read context, latency counter and registered return channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_line      <= 1'b0;
            r_beat      <= 2'd0;
            r_lat_cnt   <= '0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'd0;
        end else begin
            r_ret_valid <= w_issue;
            r_ret_last  <= w_ret_last_nxt;
            r_ret_data  <= w_ret_data_nxt;
            if (w_rd_acc) begin
                r_idx     <= w_rd_idx;
                r_line    <= w_rd_line;
                r_beat    <= 2'd0;
                r_lat_cnt <= LAT_W'(LAT_LOAD);
            end else if ((r_state == RD_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end else begin
                r_lat_cnt <= r_lat_cnt;
            end
            if (w_issue) begin
                r_beat <= w_src_beat + 2'd1;
            end
        end
    end

    // Memory write port; a line write fills all four words of the aligned line.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            if (wr_type == 3'b100) begin
                for (int k = 0; k < 4; k++) begin
                    r_mem[{w_wr_idx[AW-1:2], 2'(k)}] <= wr_data[32*k +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_wstrb[b]) begin
                        r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_bus_responder.sv
// Scoreboard bench for dcache_bus_responder: reference memory model, expected beats queued
// at read acceptance and compared as the DUT returns them.
module tb_dcache_bus_responder;

    localparam int LAT   = 2;
    localparam int WORDS = 4096;
    localparam int AW    = 12;
`ifdef DCACHE_RESP_RANDOM_STALL_EN
    localparam int NRAND = 1000;
`else
    localparam int NRAND = 300;
`endif

    logic         clk;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q [$];
    beat_t       mon_e;
    logic [31:0] ref_mem [WORDS];
    int          n_checks = 0;
    int          n_errors = 0;

    dcache_bus_responder #(
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                             input logic [127:0] d);
        int idx;
        idx = int'(a[AW+1:2]);
        if (t == 3'b100) begin
            idx = idx & ~3;
            for (int k = 0; k < 4; k++) ref_mem[idx + k] = d[32*k +: 32];
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic push_read(input logic [2:0] t, input logic [31:0] a);
        int    idx;
        beat_t e;
        idx = int'(a[AW+1:2]);
        if (t == 3'b100) begin
            idx = idx & ~3;
            for (int k = 0; k < 4; k++) begin
                e.data = ref_mem[idx + k];
                e.last = (k == 3);
                exp_q.push_back(e);
            end
        end else begin
            e.data = ref_mem[idx];
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d);
        int   n;
        logic ok;
        n = 0;
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        @(negedge clk);
        while (wr_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = wr_rdy;
        check_eq("wr_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) ref_write(t, a, s, d);
        #1 wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a);
        int   n;
        logic ok;
        n = 0;
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        @(negedge clk);
        while (rd_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = rd_rdy;
        check_eq("rd_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) push_read(t, a);
        #1 rd_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Return-channel monitor: every valid beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ret_valid === 1'b1) begin
            check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("ret_data", ret_data, mon_e.data);
                check_eq("ret_last", 32'(ret_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_type = 3'b000; rd_addr = 32'd0;
        wr_type = 3'b000; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check_eq("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        check_eq("rst_ret_valid", 32'(ret_valid), 32'd0);
        check_eq("rst_ret_last", 32'(ret_last), 32'd0);
        check_eq("rst_ret_data", ret_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Background image so every word is known to the reference model.
        for (int i = 0; i < WORDS / 4; i++) begin
            do_write(3'b100, 32'(i * 16), 4'hF,
                     {32'(i * 4 + 3) ^ 32'h5A5A_0000, 32'(i * 4 + 2) ^ 32'h5A5A_0000,
                      32'(i * 4 + 1) ^ 32'h5A5A_0000, 32'(i * 4) ^ 32'h5A5A_0000});
        end
        do_write(3'b100, 32'h400, 4'h0,
                 {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

        // Line refill with cycle-exact latency and ready checks.
        do_read(3'b100, 32'h408);
`ifndef DCACHE_RESP_RANDOM_STALL_EN
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("tim_valid_c%0d", c), 32'(ret_valid), 32'((c >= LAT) && (c < LAT + 4)));
            check_eq($sformatf("tim_last_c%0d", c), 32'(ret_last), 32'(c == LAT + 3));
            check_eq($sformatf("tim_rd_rdy_c%0d", c), 32'(rd_rdy), 32'(c == LAT + 4));
        end
        @(posedge clk);
        #1;
`endif
        drain();

        // Byte-lane write merged onto a full word.
        do_write(3'b010, 32'h20, 4'hF, 128'hDEAD_BEEF);
        do_write(3'b000, 32'h20, 4'b0010, 128'h0000_AB00);
        do_read(3'b010, 32'h20);
        drain();

        // Simultaneous requests: the write must win.
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h40; wr_wstrb = 4'h0;
        wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h40;
        @(negedge clk);
`ifndef DCACHE_RESP_RANDOM_STALL_EN
        check_eq("both_wr_rdy", 32'(wr_rdy), 32'd1);
`endif
        check_eq("both_rd_rdy", 32'(rd_rdy), 32'd0);
        n = 0;
        while (wr_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("both_wr_accept", 32'(wr_rdy), 32'd1);
        @(posedge clk);
        ref_write(3'b100, 32'h40, 4'h0, wr_data);
        #1 wr_req = 1'b0;
        do_read(3'b100, 32'h40);
        drain();

        // Address wrap and an unsupported type code treated as a word read.
        do_write(3'b010, 32'h4000_0000, 4'hF, 128'hCAFE_F00D);
        do_read(3'b010, 32'h0000_0000);
        do_read(3'b111, 32'h24);
        drain();

        // Reset during beat 2 of a line read.
        do_read(3'b100, 32'h40);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 50) begin
            @(negedge clk);
            if (ret_valid === 1'b1) seen++;
            n++;
        end
        check_eq("rst_mid_beat2_seen", 32'(seen), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        check_eq("rst_mid_ret_valid", 32'(ret_valid), 32'd0);
        check_eq("rst_mid_rd_rdy", 32'(rd_rdy), 32'd0);
        check_eq("rst_mid_wr_rdy", 32'(wr_rdy), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_hold_ret_valid", 32'(ret_valid), 32'd0);
        reset = 1'b0;
        #1;
`ifndef DCACHE_RESP_RANDOM_STALL_EN
        check_eq("rst_release_rd_rdy", 32'(rd_rdy), 32'd1);
`endif
        repeat (10) @(posedge clk);
        #1;
        do_read(3'b100, 32'h40);
        drain();

        // Random mixed traffic against the reference memory.
        for (int i = 0; i < NRAND; i++) begin
            logic [2:0]  t;
            logic [31:0] a;
            t = 3'($urandom_range(0, 7));
            a = $urandom() & 32'hC000_03FF;
            if ($urandom_range(0, 1) == 0) begin
                do_write(t, a, 4'($urandom_range(0, 15)),
                         {$urandom(), $urandom(), $urandom(), $urandom()});
            end else begin
                do_read(t, a);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
